// File: rtl/csr_trap_bank.sv
// csr_trap_bank: privilege-level CSR bank with trap entry, xRET and redirect PC.
// Optional feature macro: CSR_COUNTERS_EN (cycle/instret read-only counters).
module csr_trap_bank #(
    parameter int          XLEN    = 64,
    parameter logic [11:0] BASE    = 12'h000,
    parameter int          CAUSE_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               csr_valid,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_illegal,
    input  logic [XLEN-1:0]    pc,
    input  logic               trap_valid,
    input  logic               trap_intr,
    input  logic [CAUSE_W-1:0] trap_code,
    input  logic [XLEN-1:0]    trap_tval,
    input  logic               xret_valid,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_pc,
    input  logic               irq_sw,
    input  logic               irq_tmr,
    input  logic               irq_ext,
    output logic               irq_take,
    input  logic               retire
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [XLEN-1:0] STATUS_M = XLEN'(12'h011);
    localparam logic [XLEN-1:0] IE_M     = XLEN'(12'h111);
    localparam logic [XLEN-1:0] CAUSE_M  =
        {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, {CAUSE_W{1'b1}}};

    // one-hot register select
    localparam int S_STATUS  = 0;
    localparam int S_IE      = 1;
    localparam int S_TVEC    = 2;
    localparam int S_SCRATCH = 3;
    localparam int S_EPC     = 4;
    localparam int S_CAUSE   = 5;
    localparam int S_TVAL    = 6;
    localparam int S_IP      = 7;

    logic [XLEN-1:0] status_q, ie_q, tvec_q, scratch_q;
    logic [XLEN-1:0] epc_q, cause_q, tval_q;
    logic            ip0_q;

    logic [11:0]     off;
    logic [7:0]      sel;
    logic            cnt_hit;
    logic [XLEN-1:0] cnt_val;
    logic [XLEN-1:0] ip_val;
    logic [XLEN-1:0] old;
    logic [XLEN-1:0] nv;
    logic            write_try;
    logic            wr_en;
    logic [XLEN-1:0] vec_off;

    logic unused;
    assign unused = ^{retire, pc[0]};

    // live ip view: timer/external are wires, software bit is sticky
    always_comb begin
        ip_val    = '0;
        ip_val[0] = ip0_q | irq_sw;
        ip_val[4] = irq_tmr;
        ip_val[8] = irq_ext;
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    // free-running cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (retire)
                instret_q <= instret_q + 64'd1;
        end
    end

    // counters live at fixed addresses outside the BASE window
    always_comb begin
        cnt_hit = 1'b0;
        cnt_val = '0;
        if (csr_addr == 12'hC00) begin
            cnt_hit = 1'b1;
            cnt_val = XLEN'(cycle_q);
        end else if (csr_addr == 12'hC02) begin
            cnt_hit = 1'b1;
            cnt_val = XLEN'(instret_q);
        end
    end
`else
    assign cnt_hit = 1'b0;
    assign cnt_val = '0;
`endif

    // address decode relative to the privilege window
    always_comb begin
        off = csr_addr - BASE;
        sel = '0;
        case (off)
            12'h000: sel[S_STATUS]  = 1'b1;
            12'h004: sel[S_IE]      = 1'b1;
            12'h005: sel[S_TVEC]    = 1'b1;
            12'h040: sel[S_SCRATCH] = 1'b1;
            12'h041: sel[S_EPC]     = 1'b1;
            12'h042: sel[S_CAUSE]   = 1'b1;
            12'h043: sel[S_TVAL]    = 1'b1;
            12'h044: sel[S_IP]      = 1'b1;
            default: sel = '0;
        endcase
    end

    // read mux; unimplemented addresses read as zero
    always_comb begin
        old = cnt_val;
        unique case (1'b1)
            sel[S_STATUS]:  old = status_q;
            sel[S_IE]:      old = ie_q;
            sel[S_TVEC]:    old = tvec_q;
            sel[S_SCRATCH]: old = scratch_q;
            sel[S_EPC]:     old = epc_q;
            sel[S_CAUSE]:   old = cause_q;
            sel[S_TVAL]:    old = tval_q;
            sel[S_IP]:      old = ip_val;
            default:        old = cnt_val;
        endcase
    end

    // read-modify-write value; RS/RC with zero operand is a pure read
    always_comb begin
        nv        = old;
        write_try = 1'b0;
        case (csr_op)
            OP_RW: begin
                nv        = csr_wdata;
                write_try = 1'b1;
            end
            OP_RS: begin
                nv        = old | csr_wdata;
                write_try = |csr_wdata;
            end
            OP_RC: begin
                nv        = old & ~csr_wdata;
                write_try = |csr_wdata;
            end
            default: begin
                nv        = old;
                write_try = 1'b0;
            end
        endcase
    end

    assign wr_en = csr_valid & (|sel) & write_try
                 & ~trap_valid & ~xret_valid;

    assign csr_illegal = csr_valid
                       & (~((|sel) | cnt_hit) | (cnt_hit & write_try));

    // vectored mode only offsets interrupts
    assign vec_off = (tvec_q[1:0] == 2'b01 && trap_intr)
                   ? (XLEN'(trap_code) << 2) : '0;

    // redirect outputs, suppressed while reset is held
    always_comb begin
        redirect    = ~reset & (trap_valid | xret_valid);
        redirect_pc = '0;
        if (!reset) begin
            if (trap_valid)
                redirect_pc = {tvec_q[XLEN-1:2], 2'b00} + vec_off;
            else if (xret_valid)
                redirect_pc = epc_q;
        end
    end

    assign csr_rdata = reset ? '0 : old;
    assign irq_take  = ~reset & status_q[0] & (|(ip_val & ie_q));

    // CSR state: reset > trap > xret > instruction write
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q  <= '0;
            ie_q      <= '0;
            tvec_q    <= '0;
            scratch_q <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            ip0_q     <= 1'b0;
        end else if (trap_valid) begin
            epc_q       <= {pc[XLEN-1:1], 1'b0};
            cause_q     <= CAUSE_M & {trap_intr, {(XLEN-1-CAUSE_W){1'b0}}, trap_code};
            tval_q      <= trap_tval;
            status_q[4] <= status_q[0];
            status_q[0] <= 1'b0;
        end else if (xret_valid) begin
            status_q[0] <= status_q[4];
            status_q[4] <= 1'b1;
        end else if (wr_en) begin
            unique case (1'b1)
                sel[S_STATUS]:  status_q  <= nv & STATUS_M;
                sel[S_IE]:      ie_q      <= nv & IE_M;
                sel[S_TVEC]:    tvec_q    <= nv[1]
                                           ? {nv[XLEN-1:2], tvec_q[1:0]}
                                           : nv;
                sel[S_SCRATCH]: scratch_q <= nv;
                sel[S_EPC]:     epc_q     <= {nv[XLEN-1:1], 1'b0};
                sel[S_CAUSE]:   cause_q   <= nv & CAUSE_M;
                sel[S_TVAL]:    tval_q    <= nv;
                sel[S_IP]:      ip0_q     <= nv[0];
                default:        ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_bank.sv
// tb_csr_trap_bank: directed vectors for csr_trap_bank, queue-based scoreboard.
// Counter checks run only when CSR_COUNTERS_EN is defined.
module tb_csr_trap_bank;

    localparam int XLEN = 64;

    localparam int O_RDATA = 0;
    localparam int O_ILL   = 1;
    localparam int O_RPC   = 2;
    localparam int O_RDIR  = 3;
    localparam int O_IRQ   = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            csr_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic [XLEN-1:0] pc;
    logic            trap_valid;
    logic            trap_intr;
    logic [5:0]      trap_code;
    logic [XLEN-1:0] trap_tval;
    logic            xret_valid;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            irq_sw, irq_tmr, irq_ext;
    logic            irq_take;
    logic            retire;

    exp_t q[$];
    int   nvec = 0;
    int   nbad = 0;

    csr_trap_bank #(.XLEN(64), .BASE(12'h000), .CAUSE_W(6)) dut (
        .clk(clk), .reset(reset),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .pc(pc),
        .trap_valid(trap_valid), .trap_intr(trap_intr),
        .trap_code(trap_code), .trap_tval(trap_tval),
        .xret_valid(xret_valid), .redirect(redirect),
        .redirect_pc(redirect_pc), .irq_sw(irq_sw), .irq_tmr(irq_tmr),
        .irq_ext(irq_ext), .irq_take(irq_take), .retire(retire)
    );

    always #5 clk = ~clk;

    // monitor: outputs are settled mid-cycle; drain this cycle's expectations
    always @(negedge clk) begin
        logic [63:0] act;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            case (e.sel)
                O_RDATA: act = csr_rdata;
                O_ILL:   act = {63'd0, csr_illegal};
                O_RPC:   act = redirect_pc;
                O_RDIR:  act = {63'd0, redirect};
                default: act = {63'd0, irq_take};
            endcase
            nvec++;
            if (act !== e.val) begin
                nbad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h",
                         e.name, act, e.val);
            end
        end
    end

    task automatic expect_(input string n, input int s, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic idle();
        csr_valid  = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        pc = 0; trap_valid = 0; trap_intr = 0; trap_code = 0;
        trap_tval = 0; xret_valid = 0; retire = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a,
                       input logic [63:0] d);
        csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = d;
    endtask

    task automatic rd(input string n, input logic [11:0] a,
                      input logic [63:0] v);
        csr(2'b00, a, 64'd0);
        expect_(n, O_RDATA, v);
        expect_({n, "_ill"}, O_ILL, 64'd0);
        step();
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a,
                      input logic [63:0] d);
        csr(op, a, d);
        step();
    endtask

    logic [11:0] addrs [8] = '{12'h000, 12'h004, 12'h005, 12'h040,
                               12'h041, 12'h042, 12'h043, 12'h044};

    initial begin
        irq_sw = 0; irq_tmr = 0; irq_ext = 0;
        idle();
        reset = 1;
        step();
        // reset overrides a trap in the same cycle
        trap_valid = 1; trap_code = 6'd3; csr(2'b00, 12'h000, 0);
        expect_("rst_redirect", O_RDIR, 0);
        expect_("rst_rpc", O_RPC, 0);
        expect_("rst_rdata", O_RDATA, 0);
        step();
        reset = 0;

        foreach (addrs[i]) rd($sformatf("rst_csr%0d", i), addrs[i], 0);
        csr(2'b00, 12'h006, 0);
        expect_("illegal_006", O_ILL, 1);
        expect_("illegal_006_rd", O_RDATA, 0);
        step();

        // WARL masks and set/clear
        wr(2'b01, 12'h000, 64'hFFFF);
        rd("status_warl", 12'h000, 64'h11);
        wr(2'b10, 12'h004, 64'h100);
        rd("ie_rs", 12'h004, 64'h100);
        wr(2'b11, 12'h004, 64'h100);
        rd("ie_rc", 12'h004, 64'h0);
        wr(2'b01, 12'h005, 64'h8000_0001);
        rd("tvec", 12'h005, 64'h8000_0001);

        // interrupt trap, vectored; concurrent write is dropped
        trap_valid = 1; trap_intr = 1; trap_code = 6'd4;
        pc = 64'h1003; trap_tval = 64'hDEAD;
        csr(2'b01, 12'h040, 64'h55);
        expect_("trap_redirect", O_RDIR, 1);
        expect_("trap_rpc", O_RPC, 64'h8000_0010);
        step();
        rd("trap_epc", 12'h041, 64'h1002);
        rd("trap_cause", 12'h042, 64'h8000_0000_0000_0004);
        rd("trap_status", 12'h000, 64'h10);
        rd("trap_tval", 12'h043, 64'hDEAD);
        rd("trap_scratch", 12'h040, 0);

        // xret with a lower-priority write
        xret_valid = 1;
        csr(2'b01, 12'h040, 64'h77);
        expect_("xret_rpc", O_RPC, 64'h1002);
        expect_("xret_old_rd", O_RDATA, 0);
        step();
        rd("xret_status", 12'h000, 64'h11);
        rd("xret_scratch", 12'h040, 0);

        // tvec mode 3 keeps mode; exceptions not vectored
        wr(2'b01, 12'h005, 64'h4003);
        rd("tvec_mode", 12'h005, 64'h4001);
        trap_valid = 1; trap_code = 6'd5; pc = 64'h2000;
        expect_("exc_rpc", O_RPC, 64'h4000);
        step();
        rd("exc_cause", 12'h042, 64'h5);
        rd("exc_status", 12'h000, 64'h10);
        xret_valid = 1;
        expect_("xret2_rpc", O_RPC, 64'h2000);
        step();
        rd("xret2_status", 12'h000, 64'h11);
        wr(2'b01, 12'h041, 64'hFFFF);
        rd("epc_lsb", 12'h041, 64'hFFFE);
        wr(2'b01, 12'h042, '1);
        rd("cause_warl", 12'h042, 64'h8000_0000_0000_003F);
        wr(2'b10, 12'h040, 64'h0);
        rd("rs_zero", 12'h040, 0);

        // interrupt pending/take
        wr(2'b01, 12'h004, 64'h10);
        irq_tmr = 1;
        csr(2'b00, 12'h044, 0);
        expect_("tmr_take", O_IRQ, 1);
        expect_("tmr_ip", O_RDATA, 64'h10);
        step();
        irq_tmr = 0;
        step();
        csr(2'b00, 12'h044, 0);
        expect_("tmr_drop_ip", O_RDATA, 0);
        expect_("tmr_drop_take", O_IRQ, 0);
        step();
        irq_sw = 1;
        csr(2'b00, 12'h044, 0);
        expect_("sw_ip", O_RDATA, 64'h1);
        expect_("sw_no_take", O_IRQ, 0);
        step();
        irq_sw = 0;
        wr(2'b01, 12'h044, 64'h111);
        rd("ip_warl", 12'h044, 64'h1);
        wr(2'b01, 12'h004, 64'h1);
        expect_("ip0_take", O_IRQ, 1);
        wr(2'b11, 12'h000, 64'h1);
        expect_("ie_off_take", O_IRQ, 0);
        step();

`ifdef CSR_COUNTERS_EN
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 100; i++) begin
            retire = (i < 37);
            @(posedge clk);
            #1;
            retire = 0;
        end
        csr(2'b00, 12'hC00, 0);
        expect_("cycle_100", O_RDATA, 64'd100);
        #2;
        csr(2'b00, 12'hC02, 0);
        expect_("instret_37", O_RDATA, 64'd37);
        #2;
        csr(2'b01, 12'hC00, 64'h5);
        expect_("cycle_wr_ill", O_ILL, 1);
        @(negedge clk);
        #1;
        force dut.cycle_q = '1;
        #1;
        release dut.cycle_q;
        step();
        csr(2'b00, 12'hC00, 0);
        expect_("cycle_wrap", O_RDATA, 64'd0);
        step();
`else
        csr(2'b00, 12'hC00, 0);
        expect_("no_cycle_ill", O_ILL, 1);
        step();
`endif

        // bounded drain of pending expectations
        for (int i = 0; i < 4 && q.size() > 0; i++) step();
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
